// File: rtl/otg_hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI access sequencer.
package otg_hpi_pkg;

    localparam logic [1:0] HPI_REG_DATA    = 2'd0;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
    localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
    localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOV
    } hpi_state_t;

    typedef enum logic {
        PH_ADDR,
        PH_DATA
    } hpi_phase_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  hreg;
        logic [15:0] maddr;
        logic [15:0] wdata;
    } hpi_req_t;

    function automatic int max_of(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/otg_hpi_phase_timer.sv
// Loadable down-counter; done marks the last cycle of the loaded interval.
module otg_hpi_phase_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/otg_hpi_access_ctrl.sv
// HPI access sequencer: register and two-phase memory accesses with
// programmable setup/strobe/hold/recovery timing and chip reset hold.
module otg_hpi_access_ctrl
    import otg_hpi_pkg::*;
#(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int RECOV_CYC  = 2,
    parameter int RST_CYC    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_mem,
    input  logic [1:0]  req_reg,
    input  logic [15:0] req_maddr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        busy,
    output logic [1:0]  otg_addr,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic        otg_rst_n
);

    localparam int MAXC = max_of(max_of(max_of(SETUP_CYC, STROBE_CYC),
                                        max_of(HOLD_CYC, RECOV_CYC)),
                                 RST_CYC);
    localparam int CW = $clog2(MAXC + 1);

    hpi_state_t  state, state_d;
    hpi_phase_t  phase, phase_d;
    hpi_req_t    req_q;
    logic [15:0] rd_cap;
    logic        tmr_load;
    logic [CW-1:0] tmr_val;
    logic        tmr_done;
    logic        wr_act;
    logic        cs_act;
    logic        drv_act;

    function automatic logic [CW-1:0] cyc_of(hpi_state_t s);
        case (s)
            SETUP:   return CW'(SETUP_CYC);
            STROBE:  return CW'(STROBE_CYC);
            HOLD:    return CW'(HOLD_CYC);
            RECOV:   return CW'(RECOV_CYC);
            default: return CW'(RST_CYC);
        endcase
    endfunction

    otg_hpi_phase_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST_HOLD;
            phase <= PH_DATA;
        end else begin
            state <= state_d;
            phase <= phase_d;
        end
    end

    always_comb begin
        state_d  = state;
        phase_d  = phase;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            RST_HOLD: if (tmr_done) state_d = IDLE;
            IDLE: begin
                if (req_valid) begin
                    state_d = SETUP;
                    phase_d = req_mem ? PH_ADDR : PH_DATA;
                end
            end
            SETUP:  if (tmr_done) state_d = STROBE;
            STROBE: if (tmr_done) state_d = HOLD;
            HOLD:   if (tmr_done) state_d = RECOV;
            RECOV: begin
                if (tmr_done) begin
                    if (phase == PH_ADDR) begin
                        state_d = SETUP;
                        phase_d = PH_DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = RST_HOLD;
        endcase
        if (state_d != state) begin
            tmr_load = 1'b1;
            tmr_val  = cyc_of(state_d);
        end
        if (reset) begin
            state_d  = RST_HOLD;
            phase_d  = PH_DATA;
            tmr_load = 1'b1;
            tmr_val  = CW'(RST_CYC);
        end
    end

    // Address phase of a memory access is always an ADDRESS write.
    assign wr_act = (phase == PH_ADDR) || req_q.write;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q      <= '0;
            rd_cap     <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            if (state == IDLE && req_valid) begin
                req_q.write <= req_write;
                req_q.hreg  <= req_mem ? HPI_REG_DATA : req_reg;
                req_q.maddr <= req_maddr;
                req_q.wdata <= req_wdata;
            end
            if (state == STROBE && tmr_done && !wr_act) begin
                rd_cap <= otg_data_in;
            end
            if (state == HOLD && tmr_done && phase == PH_DATA) begin
                resp_valid <= 1'b1;
                resp_rdata <= req_q.write ? 16'h0000 : rd_cap;
            end
        end
    end

    assign cs_act  = state inside {SETUP, STROBE, HOLD};
    assign drv_act = cs_act || (state == RECOV);

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign otg_rst_n   = (state != RST_HOLD);
    assign otg_cs_n    = !cs_act;
    assign otg_wr_n    = !((state == STROBE) && wr_act);
    assign otg_rd_n    = !((state == STROBE) && !wr_act);
    assign otg_data_oe = cs_act && wr_act;

    always_comb begin
        otg_addr     = '0;
        otg_data_out = '0;
        if (drv_act) begin
            if (phase == PH_ADDR) begin
                otg_addr     = HPI_REG_ADDRESS;
                otg_data_out = req_q.maddr;
            end else begin
                otg_addr     = req_q.hreg;
                otg_data_out = req_q.wdata;
            end
        end
    end

endmodule
